// File: rtl/calc_pkg.sv
// Shared encodings for the 4-register calculator: ALU ops, write-data select and register roles.
package calc_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'b00,
    SEL_IN1  = 2'b01,
    SEL_IN2  = 2'b10,
    SEL_ALU  = 2'b11
  } sel_e;

  localparam logic [1:0] R_A   = 2'd1;
  localparam logic [1:0] R_B   = 2'd2;
  localparam logic [1:0] R_RES = 2'd3;

endpackage

// File: rtl/calc_rf.sv
// 4-entry register file: one synchronous write port, two combinational read ports with enables.
module calc_rf
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [1:0]       raa,
  input  logic             rea,
  input  logic [1:0]       rab,
  input  logic             reb,
  output logic [WIDTH-1:0] rda,
  output logic [WIDTH-1:0] rdb
);

  logic [WIDTH-1:0] mem [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-address write shows up next cycle.
  assign rda = rea ? mem[raa] : '0;
  assign rdb = reb ? mem[rab] : '0;

endmodule

// File: rtl/calc_dp.sv
// Calculator datapath: register file, write-data mux, 4-op ALU, registered result and flags.
module calc_dp
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       s1,
  input  logic [1:0]       wa,
  input  logic             we,
  input  logic [1:0]       raa,
  input  logic             rea,
  input  logic [1:0]       rab,
  input  logic             reb,
  input  logic [1:0]       c,
  input  logic             s2,
  output logic [WIDTH-1:0] out,
  output logic             zf,
  output logic             cf,
  output logic             nf
);

  logic [WIDTH-1:0] opa, opb, wdata, alu_res;
  logic             alu_cf;
  logic             alu_wb;

  // Returns {carry/borrow, result}; bit WIDTH of the zero-extended difference is the borrow.
  function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0]       op);
    logic [WIDTH:0] r;
    case (alu_op_e'(op))
      ALU_ADD: r = {1'b0, a} + {1'b0, b};
      ALU_SUB: r = {1'b0, a} - {1'b0, b};
      ALU_AND: r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  calc_rf #(.WIDTH(WIDTH)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wa),
    .wd  (wdata),
    .raa (raa),
    .rea (rea),
    .rab (rab),
    .reb (reb),
    .rda (opa),
    .rdb (opb)
  );

  assign {alu_cf, alu_res} = alu_f(opa, opb, c);

  always_comb begin
    wdata = '0;
    case (sel_e'(s1))
      SEL_ZERO: wdata = '0;
      SEL_IN1:  wdata = in1;
      SEL_IN2:  wdata = in2;
      default:  wdata = alu_res;
    endcase
  end

  assign alu_wb = we && (sel_e'(s1) == SEL_ALU);

  // Result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      zf  <= 1'b0;
      cf  <= 1'b0;
      nf  <= 1'b0;
    end else begin
      if (s2) out <= alu_res;
      if (alu_wb) begin
        zf <= (alu_res == '0);
        cf <= alu_cf;
        nf <= alu_res[WIDTH-1];
      end
    end
  end

endmodule
